// File: rtl/sync_to_valid_gen.sv
// sync_to_valid_gen
//   Converts the raw hsync/vsync pulses from the SDI receiver into frame valid
//   (fv_o) and line valid (lv_o) for the CSI-2 packetiser. Porches, active area
//   and sync polarity are parameters. Short lines and short frames raise sticky
//   error flags. line_idx_o reports the index of the current active line.
//
//   Ports:
//     sys_clk           pixel clock
//     sys_rst           asynchronous, active-high reset
//     vsync_i, hsync_i  raw syncs, asserted level given by VSYNC_POL / HSYNC_POL
//     err_clr_i         synchronous pulse, clears both sticky error flags
//     fv_o, lv_o        frame valid / line valid (lv_o only while fv_o)
//     line_idx_o        active line index, 0..V_ACTIVE-1
//     err_short_line_o  sticky: hsync arrived while lv_o was high
//     err_short_frame_o sticky: vsync arrived before V_ACTIVE lines completed
//
//   Optional build macro SYNC_TO_VALID_STATS_EN adds:
//     line_len_o        cycles between the last two line starts
//     frame_lines_o     line starts counted in the last complete frame
module sync_to_valid_gen #(
  parameter int   H_ACTIVE     = 1280,
  parameter int   H_BACK_PORCH = 220,
  parameter int   V_ACTIVE     = 720,
  parameter int   V_BACK_PORCH = 20,
  parameter int   CNT_W        = 12,
  parameter logic HSYNC_POL    = 1'b1,
  parameter logic VSYNC_POL    = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             vsync_i,
  input  logic             hsync_i,
  input  logic             err_clr_i,
  output logic             fv_o,
  output logic             lv_o,
  output logic [CNT_W-1:0] line_idx_o,
  output logic             err_short_line_o,
  output logic             err_short_frame_o
`ifdef SYNC_TO_VALID_STATS_EN
  ,
  output logic [CNT_W:0]   line_len_o,
  output logic [CNT_W-1:0] frame_lines_o
`endif
);

  localparam logic [CNT_W-1:0] H_BP_LAST  = CNT_W'(H_BACK_PORCH - 1);
  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_BP_CNT   = CNT_W'(V_BACK_PORCH);
  localparam logic [CNT_W-1:0] V_LAST_IDX = CNT_W'(V_ACTIVE - 1);

  typedef enum logic [1:0] {H_IDLE, H_BP, H_ACT} h_state_t;
  typedef enum logic [1:0] {V_IDLE, V_BP, V_ACT} v_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Sync sampling: two registers per sync, start = trailing edge of assertion
  logic hs_act, vs_act;
  logic hs_q1, hs_q2, vs_q1, vs_q2;
  logic line_start, frame_start;

  assign hs_act = (hsync_i == HSYNC_POL);
  assign vs_act = (vsync_i == VSYNC_POL);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hs_q1 <= 1'b0;
      hs_q2 <= 1'b0;
      vs_q1 <= 1'b0;
      vs_q2 <= 1'b0;
    end else begin
      hs_q1 <= hs_act;
      hs_q2 <= hs_q1;
      vs_q1 <= vs_act;
      vs_q2 <= vs_q1;
    end
  end

  assign line_start  = hs_q2 & ~hs_q1;
  assign frame_start = vs_q2 & ~vs_q1;

  // Next-cycle decisions shared by both state machines
  h_state_t         h_state;
  v_state_t         v_state;
  logic [CNT_W-1:0] pix_cnt, line_cnt;
  logic             v_end_p;
  logic             cnt_inc, v_go_act, v_go_idle, fv_nxt, h_act_nxt, lv_nxt;

  // While vsync is still asserted the line counter holds.
  assign cnt_inc   = line_start & ~vs_q1;
  // A frame_start coinciding with a line_start counts that line as 1.
  assign v_go_act  = frame_start ? (line_start && (V_BP_CNT == CNT_W'(1)))
                                 : (v_state == V_BP && cnt_inc && sat_inc(line_cnt) == V_BP_CNT);
  // Frame ends one cycle after the last line's lv_o falls, or when an extra
  // line starts during the last active line.
  assign v_go_idle = !frame_start && v_state == V_ACT &&
                     (v_end_p || (line_start && line_idx_o == V_LAST_IDX));
  assign fv_nxt    = !frame_start && (v_go_act || (fv_o && !v_go_idle));
  assign h_act_nxt = !line_start &&
                     ((h_state == H_BP  && pix_cnt == H_BP_LAST) ||
                      (h_state == H_ACT && pix_cnt != H_ACT_LAST));
  assign lv_nxt    = h_act_nxt && fv_nxt;

  // Horizontal FSM
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_state <= H_IDLE;
      pix_cnt <= '0;
      lv_o    <= 1'b0;
    end else begin
      lv_o <= lv_nxt;
      if (line_start) begin
        h_state <= H_BP;
        pix_cnt <= '0;
      end else begin
        case (h_state)
          H_BP: begin
            if (pix_cnt == H_BP_LAST) begin
              h_state <= H_ACT;
              pix_cnt <= '0;
            end else begin
              pix_cnt <= sat_inc(pix_cnt);
            end
          end
          H_ACT: begin
            if (pix_cnt == H_ACT_LAST) begin
              h_state <= H_IDLE;
              pix_cnt <= '0;
            end else begin
              pix_cnt <= sat_inc(pix_cnt);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Vertical FSM
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      v_state    <= V_IDLE;
      line_cnt   <= '0;
      line_idx_o <= '0;
      fv_o       <= 1'b0;
      v_end_p    <= 1'b0;
    end else begin
      fv_o    <= fv_nxt;
      v_end_p <= (v_state == V_ACT) && (line_idx_o == V_LAST_IDX) && lv_o && !lv_nxt &&
                 !frame_start && !line_start;
      if (frame_start) begin
        line_cnt <= line_start ? CNT_W'(1) : '0;
        v_state  <= v_go_act ? V_ACT : V_BP;
        if (v_go_act) line_idx_o <= '0;
      end else begin
        case (v_state)
          V_BP: begin
            if (cnt_inc) begin
              line_cnt <= sat_inc(line_cnt);
              if (v_go_act) begin
                v_state    <= V_ACT;
                line_idx_o <= '0;
              end
            end
          end
          V_ACT: begin
            if (v_go_idle) begin
              v_state <= V_IDLE;
            end else if (line_start) begin
              line_cnt   <= sat_inc(line_cnt);
              line_idx_o <= sat_inc(line_cnt) - V_BP_CNT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky error flags; a new error wins over a clear in the same cycle
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err_short_line_o  <= 1'b0;
      err_short_frame_o <= 1'b0;
    end else begin
      if (line_start && lv_o)             err_short_line_o <= 1'b1;
      else if (err_clr_i)                 err_short_line_o <= 1'b0;
      if (frame_start && v_state == V_ACT) err_short_frame_o <= 1'b1;
      else if (err_clr_i)                  err_short_frame_o <= 1'b0;
    end
  end

`ifdef SYNC_TO_VALID_STATS_EN
  function automatic logic [CNT_W:0] sat_inc_len(input logic [CNT_W:0] v);
    return (&v) ? v : v + (CNT_W+1)'(1);
  endfunction

  logic [CNT_W:0]   len_cnt;
  logic [CNT_W-1:0] fl_cnt;

  // len_cnt reads N-1 in the cycle of a line_start that is N cycles after the previous one
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      len_cnt       <= '0;
      fl_cnt        <= '0;
      line_len_o    <= '0;
      frame_lines_o <= '0;
    end else begin
      if (line_start) begin
        line_len_o <= sat_inc_len(len_cnt);
        len_cnt    <= '0;
      end else begin
        len_cnt <= sat_inc_len(len_cnt);
      end
      if (frame_start) begin
        frame_lines_o <= fl_cnt;
        fl_cnt        <= line_start ? CNT_W'(1) : '0;
      end else if (line_start) begin
        fl_cnt <= sat_inc(fl_cnt);
      end
    end
  end
`endif

endmodule

// File: doc/sync_to_valid_gen.md
Name: sync_to_valid_gen

Overview:
- Parametrised successor to the hsync/vsync-to-frame/line-valid converter in the SDI-to-MIPI path.
- Converts raw sync pulses from the SDI receiver into fv_o/lv_o for the CSI-2 packetiser.
- Sync polarity, porches and active area are set by parameters.
- Adds short-line and short-frame detection, sticky error flags and an active-line index output.

Parameters:
- H_ACTIVE, 1280, active pixels per line (lv_o high cycles)
- H_BACK_PORCH, 220, cycles from the hsync-deassert sample to the first lv_o cycle
- V_ACTIVE, 720, active lines per frame
- V_BACK_PORCH, 20, lines after vsync deassert before the first active line
- CNT_W, 12, width of the pixel and line counters; must hold max(H_BACK_PORCH+H_ACTIVE, V_BACK_PORCH+V_ACTIVE)
- HSYNC_POL, 1, asserted level of hsync_i
- VSYNC_POL, 1, asserted level of vsync_i

Ports:
- sys_clk  in  1  pixel clock
- sys_rst  in  1  asynchronous, active-high reset
- vsync_i  in  1  vertical sync, level per VSYNC_POL
- hsync_i  in  1  horizontal sync, level per HSYNC_POL
- fv_o  out  1  frame valid
- lv_o  out  1  line valid; only ever high while fv_o is high
- line_idx_o  out  CNT_W  index of the current active line, 0..V_ACTIVE-1
- err_short_line_o  out  1  sticky: an hsync arrived during lv_o
- err_short_frame_o  out  1  sticky: a vsync arrived before V_ACTIVE lines completed
- err_clr_i  in  1  synchronous pulse; clears both sticky flags

Behaviour:
- Reset: all outputs 0; both FSMs idle; counters 0.
- Input sampling:
  - hs_act = (hsync_i == HSYNC_POL); vs_act likewise.
  - Each is registered twice (q1, q2).
  - line_start = q2 & ~q1; frame_start uses the same form on vsync.
  - An hsync deassert sampled at edge N gives line_start high during cycle N+1.
- H FSM: H_IDLE -> H_BP on line_start; pixel counter cleared to 0.
  - H_BP -> H_ACT when the counter reaches H_BACK_PORCH-1.
  - H_ACT -> H_IDLE after H_ACTIVE cycles.
  - lv_o = (H state == H_ACT) & fv_o, registered. lv_o first rises at edge N+1+H_BACK_PORCH and stays high exactly H_ACTIVE cycles.
- V FSM: V_IDLE -> V_BP on frame_start; line counter cleared.
  - Each line_start increments the line counter.
  - On the line_start that takes the counter to V_BACK_PORCH, go to V_ACT; fv_o rises in that same cycle, i.e. H_BACK_PORCH cycles before the first lv_o.
  - In V_ACT, line_idx_o = line counter - V_BACK_PORCH.
  - fv_o falls 1 cycle after the falling edge of the lv_o of line V_ACTIVE-1; then go to V_IDLE.
  - line_idx_o holds its last value until the next frame reaches V_ACT.
- Sync asserted (q1 active) in V_IDLE or V_BP: counters hold; nothing else happens.
- Short line (line_start while in H_ACT):
  - lv_o drops in that cycle; err_short_line_o set.
  - The new line starts normally: H_BP, counter 0.
  - The truncated line still counts as a line.
- Short frame (frame_start while in V_ACT):
  - fv_o and lv_o drop in that cycle; err_short_frame_o set; V goes to V_BP for the new frame.
- frame_start and line_start in the same cycle: process frame_start first, then count that line_start as line 0 of the new frame's V_BP (counter = 1).
- Error flags: set has priority over err_clr_i in the same cycle.
- Reset asserted mid-line: outputs go to 0 immediately (asynchronous). After release, the first valid frame begins at the next frame_start.
- Counters saturate at 2^CNT_W-1; they never wrap.

Optional Feature:
- Macro: SYNC_TO_VALID_STATS_EN.
- When defined, adds two outputs:
  - line_len_o (CNT_W+1 bits): cycles between the last two line_starts.
  - frame_lines_o (CNT_W bits): line_starts counted in the last complete frame.
  - Both reset to 0, update on line_start / frame_start respectively, and saturate.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Nominal, params H_ACTIVE=8, H_BACK_PORCH=3, V_ACTIVE=4, V_BACK_PORCH=2, syncs 2 cycles, line 20 cycles, frame 8 lines:
  - exactly 4 lv_o pulses of 8 cycles each;
  - each pulse rises 4 cycles after its hsync-deassert edge;
  - fv_o rises 3 cycles before the first lv_o and falls 1 cycle after the last;
  - line_idx_o steps 0..3; no errors.
- HSYNC_POL=0, VSYNC_POL=0 with inverted stimulus -> waveforms identical to the nominal case.
- hsync inserted 5 cycles into the lv_o of line 1 -> lv_o high only 5 cycles, err_short_line_o=1, line 2 normal; err_clr_i pulse -> flag 0.
- vsync after 2 active lines -> fv_o drops in the frame_start cycle, err_short_frame_o=1; next frame has full 4 lines.
- sys_rst pulsed mid-lv_o -> fv_o=lv_o=0 immediately; no lv_o until after the next vsync plus 2 back-porch lines.
- With SYNC_TO_VALID_STATS_EN: nominal stimulus -> line_len_o=20, frame_lines_o=8 after the second frame.
